decode_stage: RTL and testbench
===============================

// Module: decode_stage
//
// PURPOSE
// - Registered, handshaked instruction-decode stage; parametrised successor of the combinational field splitter.
// - Sits between fetch and register-read: accepts {pc, inst} from fetch and presents decoded fields to register-read.
// - Adds a 2-entry skid buffer (valid/ready), flush, sign-extended immediates and a decoded-instruction counter.
//
// PARAMETERS
// - ARCH_BITS  32  instruction/data width; must equal OPC_BITS + 3*REG_BITS + IMM_BITS (elaboration-time check)
// - OPC_BITS   7   opcode field width
// - REG_BITS   5   register specifier width (dst/src1/src2)
// - IMM_BITS   10  immediate field width; derived as ARCH_BITS-OPC_BITS-3*REG_BITS, not overridable
// - OFF_BITS   15  short-offset width, OFF_BITS = REG_BITS+IMM_BITS
// - CNT_BITS   32  width of the decoded-instruction counter
//
// PORTS
// - clk         in   1          clock, rising edge
// - rst         in   1          asynchronous, active-high reset
// - flush       in   1          synchronous: discard all buffered instructions
// - in_valid    in   1          fetch presents an instruction
// - in_ready    out  1          stage can accept; equals "skid entry empty"
// - in_inst     in   ARCH_BITS  raw instruction
// - in_pc       in   ARCH_BITS  instruction PC
// - out_valid   out  1          decoded instruction available
// - out_ready   in   1          register-read accepts
// - out_pc      out  ARCH_BITS  PC of presented instruction
// - opcode      out  OPC_BITS   inst[AB-1 -: OPC]                  (32b: [31:25])
// - dst         out  REG_BITS   next REG_BITS below opcode          (32b: [24:20])
// - src1        out  REG_BITS   next field                          (32b: [19:15])
// - src2        out  REG_BITS   next field                          (32b: [14:10])
// - imm_sext    out  ARCH_BITS  sign-extended inst[IMM_BITS-1:0]
// - offset_sext out  ARCH_BITS  sign-extended inst[OFF_BITS-1:0]
// - loff_sext   out  ARCH_BITS  sign-extended {dst, src2, imm} (offsetHi/offsetM/offsetLo), 2*REG+IMM bits
// - dec_count   out  CNT_BITS   instructions handed to register-read since reset
//
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, all field/pc outputs=0, dec_count=0, both entries empty.
// - Latency 1 cycle: accepted at edge N (in_valid&in_ready) -> visible with out_valid=1 after edge N.
// - Storage: main entry M (drives outputs) + skid entry S. Stores raw {pc,inst}; field split/sign-ext combinational from M.
// - Transfer out: out_valid&out_ready at an edge. Transfer in: in_valid&in_ready.
// - States (from M.v, S.v): EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) unreachable; assertion.
//   - EMPTY: in -> ONE (load M).
//   - ONE: in&!out -> FULL (load S); in&out -> ONE (reload M); !in&out -> EMPTY; else hold.
//   - FULL: in_ready=0; out -> ONE (M<=S, S cleared); else hold.
// - in_ready is registered-equivalent (depends only on S.v), never on out_ready: no comb path in->out.
// - Outputs hold stable while out_valid&!out_ready.
// - flush: next state EMPTY regardless of handshakes; a same-cycle in transfer is dropped; a same-cycle out transfer
//   still counts (register-read has taken it). Field outputs keep last value (don't-care while out_valid=0).
// - dec_count increments by 1 per out transfer; wraps modulo 2^CNT_BITS; not cleared by flush.
// - Sign extension: replicate MSB of the source field to ARCH_BITS. Widths unsigned otherwise.
// - Reset mid-operation: immediate return to reset values; no partial transfers survive.
// - Order preserved: M always older than S.
//
// STRUCTURE
// - Shared package decode_pkg: ARCH_BITS/OPC_BITS/REG_BITS defaults, derived IMM_BITS/OFF_BITS/LOFF_BITS,
//   field-position localparams, typedef struct {pc, inst} fetch_pkt_t, function sext().
// - One sub-module: inst_fields (pure combinational split + sign-extension of a raw inst), instantiated on M.
// - Skid-buffer control and counter in decode_stage itself.
//
// TESTING
// - Decode: inst=32'h8A33B3FF, pc=32'h100, out_ready=1 -> next cycle opcode=7'h45, dst=3, src1=7, src2=12,
//   imm_sext=32'hFFFFFFFF, offset_sext=32'h000033FF, loff_sext=32'h0001B3FF, out_pc=32'h100, dec_count=1.
// - Backpressure: out_ready=0, stream A,B,C -> A held on outputs, B in skid, in_ready=0, C not taken;
//   raise out_ready -> A,B,C delivered in order, one per cycle, dec_count=3.
// - Full throughput: in_valid=out_ready=1 for 100 cycles -> 100 transfers, in_ready never 0, dec_count=100.
// - Flush in FULL with out_ready=1: M delivered (dec_count+1), next cycle out_valid=0, in_ready=1, S lost.
// - Counter wrap: CNT_BITS=4, 17 transfers -> dec_count=1.
// - Async reset asserted mid-stream between edges -> out_valid=0, dec_count=0 immediately, before next clk.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: default field geometry, state encoding,
// fetch packet type and width/sign-extension helpers.
package decode_pkg;

    localparam int DEF_ARCH_BITS = 32;
    localparam int DEF_OPC_BITS  = 7;
    localparam int DEF_REG_BITS  = 5;
    localparam int DEF_CNT_BITS  = 32;

    // State encoding is {M.valid, S.valid}; 2'b01 can never occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [DEF_ARCH_BITS-1:0] pc;
        logic [DEF_ARCH_BITS-1:0] inst;
    } fetch_pkt_t;

    function automatic int imm_bits(input int arch_bits, input int opc_bits, input int reg_bits);
        return arch_bits - opc_bits - 3 * reg_bits;
    endfunction

    function automatic int off_bits(input int arch_bits, input int opc_bits, input int reg_bits);
        return reg_bits + imm_bits(arch_bits, opc_bits, reg_bits);
    endfunction

    function automatic int loff_bits(input int arch_bits, input int opc_bits, input int reg_bits);
        return 2 * reg_bits + imm_bits(arch_bits, opc_bits, reg_bits);
    endfunction

    // MSB positions of the register fields, counted down from the opcode.
    function automatic int dst_msb(input int arch_bits, input int opc_bits);
        return arch_bits - opc_bits - 1;
    endfunction

    function automatic int src1_msb(input int arch_bits, input int opc_bits, input int reg_bits);
        return dst_msb(arch_bits, opc_bits) - reg_bits;
    endfunction

    function automatic int src2_msb(input int arch_bits, input int opc_bits, input int reg_bits);
        return src1_msb(arch_bits, opc_bits, reg_bits) - reg_bits;
    endfunction

    // Sign-extends the low 'bits' bits of v to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned bits);
        logic signed [63:0] t;
        t = $signed(v << (64 - bits));
        return t >>> (64 - bits);
    endfunction

endpackage

// File: rtl/decode_stage_inst_fields.sv
// Pure combinational split of a raw instruction into its fields plus the three
// sign-extended immediate views.
module inst_fields
    import decode_pkg::*;
#(
    parameter int ARCH_BITS = DEF_ARCH_BITS,
    parameter int OPC_BITS  = DEF_OPC_BITS,
    parameter int REG_BITS  = DEF_REG_BITS
) (
    input  logic [ARCH_BITS-1:0] inst,
    output logic [OPC_BITS-1:0]  opcode,
    output logic [REG_BITS-1:0]  dst,
    output logic [REG_BITS-1:0]  src1,
    output logic [REG_BITS-1:0]  src2,
    output logic [ARCH_BITS-1:0] imm_sext,
    output logic [ARCH_BITS-1:0] offset_sext,
    output logic [ARCH_BITS-1:0] loff_sext
);

    localparam int IMM_BITS  = imm_bits(ARCH_BITS, OPC_BITS, REG_BITS);
    localparam int OFF_BITS  = off_bits(ARCH_BITS, OPC_BITS, REG_BITS);
    localparam int LOFF_BITS = loff_bits(ARCH_BITS, OPC_BITS, REG_BITS);
    localparam int DST_MSB   = dst_msb(ARCH_BITS, OPC_BITS);
    localparam int SRC1_MSB  = src1_msb(ARCH_BITS, OPC_BITS, REG_BITS);
    localparam int SRC2_MSB  = src2_msb(ARCH_BITS, OPC_BITS, REG_BITS);

    logic [LOFF_BITS-1:0] loff_raw;

    assign opcode = inst[ARCH_BITS-1 -: OPC_BITS];
    assign dst    = inst[DST_MSB -: REG_BITS];
    assign src1   = inst[SRC1_MSB -: REG_BITS];
    assign src2   = inst[SRC2_MSB -: REG_BITS];

    // The long offset skips src1: {dst, src2, imm}.
    assign loff_raw = {dst, src2, inst[IMM_BITS-1:0]};

    assign imm_sext    = ARCH_BITS'(sext(64'(inst[IMM_BITS-1:0]), IMM_BITS));
    assign offset_sext = ARCH_BITS'(sext(64'(inst[OFF_BITS-1:0]), OFF_BITS));
    assign loff_sext   = ARCH_BITS'(sext(64'(loff_raw), LOFF_BITS));

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage: two-entry skid buffer holding raw {pc, inst},
// combinational field decode of the main entry, and a delivered-instruction counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int ARCH_BITS = DEF_ARCH_BITS,
    parameter int OPC_BITS  = DEF_OPC_BITS,
    parameter int REG_BITS  = DEF_REG_BITS,
    parameter int CNT_BITS  = DEF_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ARCH_BITS-1:0] in_inst,
    input  logic [ARCH_BITS-1:0] in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ARCH_BITS-1:0] out_pc,
    output logic [OPC_BITS-1:0]  opcode,
    output logic [REG_BITS-1:0]  dst,
    output logic [REG_BITS-1:0]  src1,
    output logic [REG_BITS-1:0]  src2,
    output logic [ARCH_BITS-1:0] imm_sext,
    output logic [ARCH_BITS-1:0] offset_sext,
    output logic [ARCH_BITS-1:0] loff_sext,
    output logic [CNT_BITS-1:0]  dec_count
);

    localparam int IMM_BITS = imm_bits(ARCH_BITS, OPC_BITS, REG_BITS);

    if (IMM_BITS < 1) begin : g_bad_geometry
        $error("decode_stage: ARCH_BITS too small for OPC_BITS + 3*REG_BITS");
    end
    if (ARCH_BITS > 64) begin : g_bad_width
        $error("decode_stage: ARCH_BITS above 64 is not supported");
    end

    typedef struct packed {
        logic [ARCH_BITS-1:0] pc;
        logic [ARCH_BITS-1:0] inst;
    } pkt_t;

    state_t state;
    pkt_t   m_pkt;
    pkt_t   s_pkt;
    pkt_t   in_pkt;
    logic   xfer_in;
    logic   xfer_out;

    // in_ready depends only on the skid entry, so there is no combinational path to out_ready.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;
    assign in_pkt    = '{pc: in_pc, inst: in_inst};
    assign out_pc    = m_pkt.pc;

    // Skid-buffer sequencing; flush overrides every handshake but a delivered instruction still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            m_pkt     <= '0;
            s_pkt     <= '0;
            dec_count <= '0;
        end else begin
            if (xfer_out) begin
                dec_count <= dec_count + CNT_BITS'(1);
            end
            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (xfer_in) begin
                            m_pkt <= in_pkt;
                            state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (xfer_in && !out_ready) begin
                            s_pkt <= in_pkt;
                            state <= ST_FULL;
                        end else if (xfer_in && out_ready) begin
                            m_pkt <= in_pkt;
                        end else if (out_ready) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (out_ready) begin
                            m_pkt <= s_pkt;
                            s_pkt <= '0;
                            state <= ST_ONE;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

    inst_fields #(
        .ARCH_BITS(ARCH_BITS),
        .OPC_BITS (OPC_BITS),
        .REG_BITS (REG_BITS)
    ) u_fields (
        .inst       (m_pkt.inst),
        .opcode     (opcode),
        .dst        (dst),
        .src1       (src1),
        .src2       (src2),
        .imm_sext   (imm_sext),
        .offset_sext(offset_sext),
        .loff_sext  (loff_sext)
    );

    a_no_skid_without_main: assert property (@(posedge clk) disable iff (rst) state != 2'b01);

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, imm_sext, offset_sext, loff_sext, dec_count;
    logic [6:0]  opcode;
    logic [4:0]  dst, src1, src2;

    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_pc, n_imm_sext, n_offset_sext, n_loff_sext;
    logic [6:0]  n_opcode;
    logic [4:0]  n_dst, n_src1, n_src2;
    logic [3:0]  n_dec_count;

    int checks   = 0;
    int failures = 0;

    fetch_pkt_t pktA, pktB, pktC;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .dst(dst), .src1(src1), .src2(src2),
        .imm_sext(imm_sext), .offset_sext(offset_sext), .loff_sext(loff_sext),
        .dec_count(dec_count)
    );

    decode_stage #(.CNT_BITS(4)) dut_narrow (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .opcode(n_opcode), .dst(n_dst), .src1(n_src1), .src2(n_src2),
        .imm_sext(n_imm_sext), .offset_sext(n_offset_sext), .loff_sext(n_loff_sext),
        .dec_count(n_dec_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic ordy);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Streams n back-to-back instructions with out_ready held high, then drains the last one.
    task automatic runStream(input int n, output int delivered, output int stalls, output int orderErr);
        logic [31:0] expPc;
        delivered = 0;
        stalls    = 0;
        orderErr  = 0;
        expPc     = 32'h0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 32'(i) * 4, 1'b1);
            if (in_ready !== 1'b1) stalls++;
            if (out_valid === 1'b1) begin
                if (out_pc !== expPc) orderErr++;
                expPc += 4;
                delivered++;
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        if (out_valid === 1'b1) begin
            if (out_pc !== expPc) orderErr++;
            delivered++;
        end
        tick();
    endtask

    initial begin
        int delivered, stalls, orderErr;
        rst = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);

        pktA = '{pc: 32'h200, inst: 32'h0A00_0001};
        pktB = '{pc: 32'h204, inst: 32'h1400_0002};
        pktC = '{pc: 32'h208, inst: 32'h1E00_0003};

        // Reset state
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
        checkOutput("rst_opcode", 64'(opcode), 64'd0);
        checkOutput("rst_imm", 64'(imm_sext), 64'd0);
        checkOutput("rst_count", 64'(dec_count), 64'd0);

        // Single decode
        doReset();
        applyStimulus(1'b1, 32'h8A33_B3FF, 32'h100, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("dec_valid", 64'(out_valid), 64'd1);
        checkOutput("dec_opcode", 64'(opcode), 64'h45);
        checkOutput("dec_dst", 64'(dst), 64'd3);
        checkOutput("dec_src1", 64'(src1), 64'd7);
        checkOutput("dec_src2", 64'(src2), 64'd12);
        checkOutput("dec_imm", 64'(imm_sext), 64'hFFFF_FFFF);
        checkOutput("dec_offset", 64'(offset_sext), 64'h0000_33FF);
        checkOutput("dec_loff", 64'(loff_sext), 64'h0001_B3FF);
        checkOutput("dec_pc", 64'(out_pc), 64'h100);
        tick();
        checkOutput("dec_count", 64'(dec_count), 64'd1);
        checkOutput("dec_drained", 64'(out_valid), 64'd0);

        // Backpressure: A held, B in skid, C refused until room appears
        doReset();
        applyStimulus(1'b1, pktA.inst, pktA.pc, 1'b0);
        tick();
        applyStimulus(1'b1, pktB.inst, pktB.pc, 1'b0);
        tick();
        applyStimulus(1'b1, pktC.inst, pktC.pc, 1'b0);
        checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
        checkOutput("bp_pc_a", 64'(out_pc), 64'h200);
        checkOutput("bp_opcode_a", 64'(opcode), 64'h05);
        tick();
        checkOutput("bp_hold_pc", 64'(out_pc), 64'h200);
        checkOutput("bp_hold_count", 64'(dec_count), 64'd0);
        applyStimulus(1'b1, pktC.inst, pktC.pc, 1'b1);
        tick();
        checkOutput("bp_pc_b", 64'(out_pc), 64'h204);
        checkOutput("bp_in_ready_one", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("bp_pc_c", 64'(out_pc), 64'h208);
        checkOutput("bp_opcode_c", 64'(opcode), 64'h0F);
        tick();
        checkOutput("bp_empty", 64'(out_valid), 64'd0);
        checkOutput("bp_count", 64'(dec_count), 64'd3);

        // Full throughput
        doReset();
        runStream(100, delivered, stalls, orderErr);
        checkOutput("tput_delivered", 64'(delivered), 64'd100);
        checkOutput("tput_stalls", 64'(stalls), 64'd0);
        checkOutput("tput_order", 64'(orderErr), 64'd0);
        checkOutput("tput_count", 64'(dec_count), 64'd100);
        checkOutput("tput_narrow_count", 64'(n_dec_count), 64'd4);

        // Counter wrap on the 4-bit instance
        doReset();
        runStream(17, delivered, stalls, orderErr);
        checkOutput("wrap_count32", 64'(dec_count), 64'd17);
        checkOutput("wrap_count4", 64'(n_dec_count), 64'd1);

        // Flush while FULL with out_ready high: M delivered, S discarded
        doReset();
        applyStimulus(1'b1, 32'h1111_1111, 32'h300, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h2222_2222, 32'h304, 1'b0);
        tick();
        checkOutput("fl_full", 64'(in_ready), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
        checkOutput("fl_count", 64'(dec_count), 64'd1);
        tick();
        checkOutput("fl_skid_lost", 64'(out_valid), 64'd0);

        // Flush drops a same-cycle input transfer
        doReset();
        applyStimulus(1'b1, 32'h3333_3333, 32'h400, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("fl_drop_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_drop_count", 64'(dec_count), 64'd0);

        // Asynchronous reset between edges
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h4000_0000 + 32'(i), 32'h500 + 32'(i) * 4, 1'b1);
            tick();
        end
        checkOutput("ar_pre_count", 64'(dec_count), 64'd4);
        checkOutput("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid", 64'(out_valid), 64'd0);
        checkOutput("ar_count", 64'(dec_count), 64'd0);
        checkOutput("ar_in_ready", 64'(in_ready), 64'd1);
        checkOutput("ar_out_pc", 64'(out_pc), 64'd0);
        checkOutput("ar_narrow_count", 64'(n_dec_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
